// File: rtl/seg7_scan_reader_if.sv
// Bundle of the scanned-display sense signals and the decoded results.
//   segIn       : {dp, A..G} sensed from the display, active-high, asynchronous to clk
//   digitSelIn  : one-hot digit select sensed from the display, asynchronous to clk
//   valOut      : decoded nibble per digit, digit i at [4i+3:4i]
//   dpOut       : captured decimal point per digit
//   validOut    : digit holds a recognised, non-stale hex pattern
//   errOut      : last capture of the digit was neither hex nor blank
//   newOut      : one-cycle pulse per capture
//   digitIdxOut : index of the captured digit, meaningful while newOut=1
// master drives the display side; slave is the reader.
interface seg7_scan_reader_if #(
   parameter int unsigned DIGITS = 4
);
   logic [7:0]          segIn;
   logic [DIGITS-1:0]   digitSelIn;
   logic [4*DIGITS-1:0] valOut;
   logic [DIGITS-1:0]   dpOut;
   logic [DIGITS-1:0]   validOut;
   logic [DIGITS-1:0]   errOut;
   logic                newOut;
   logic [2:0]          digitIdxOut;

   modport master (
      output segIn, digitSelIn,
      input  valOut, dpOut, validOut, errOut, newOut, digitIdxOut
   );

   modport slave (
      input  segIn, digitSelIn,
      output valOut, dpOut, validOut, errOut, newOut, digitIdxOut
   );
endinterface

// File: rtl/seg7_scan_reader.sv
// Receive side of a multiplexed 7-segment display. Synchronises the sensed segment bus
// and digit select, waits for a stable run, then decodes the pattern back to a hex
// nibble, decimal point and status for the selected digit.
// Ports:
//   clk  : system clock
//   rstN : asynchronous active-low reset
//   bus  : seg7_scan_reader_if slave (segIn/digitSelIn in, decoded results out)
module seg7_scan_reader #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input logic               clk,
   input logic               rstN,
   seg7_scan_reader_if.slave bus
);
   localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
   localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StTrack = 2'd1;
   localparam logic [1:0] StHeld  = 2'd2;

   logic [7:0]          segMeta, sSeg, prevSeg;
   logic [DIGITS-1:0]   selMeta, sSel, prevSel;
   logic [CntW-1:0]     cnt, cntD;
   logic [1:0]          state, stateD;
   logic [4*DIGITS-1:0] valQ;
   logic [DIGITS-1:0]   dpQ, validQ, errQ;
   logic                newQ;
   logic [2:0]          idxQ, capIdx;
   logic [TmoW-1:0]     tmo [DIGITS];

   logic       oneHot, changed, capture, hit, blank;
   logic [3:0] nib;

   // Returns {hit, nibble}; dp is excluded by the caller.
   function automatic logic [4:0] decodeHex(input logic [6:0] p);
      case (p)
         7'b1111110: decodeHex = 5'h10;
         7'b0110000: decodeHex = 5'h11;
         7'b1101101: decodeHex = 5'h12;
         7'b1111001: decodeHex = 5'h13;
         7'b0110011: decodeHex = 5'h14;
         7'b1011011: decodeHex = 5'h15;
         7'b1011111: decodeHex = 5'h16;
         7'b1110000: decodeHex = 5'h17;
         7'b1111111: decodeHex = 5'h18;
         7'b1111011: decodeHex = 5'h19;
         7'b1110111: decodeHex = 5'h1A;
         7'b0011111: decodeHex = 5'h1B;
         7'b1001110: decodeHex = 5'h1C;
         7'b0111101: decodeHex = 5'h1D;
         7'b1001111: decodeHex = 5'h1E;
         7'b1000111: decodeHex = 5'h1F;
         default:    decodeHex = 5'h00;
      endcase
   endfunction

   always_comb begin
      oneHot  = (sSel != '0) && ((sSel & (sSel - DIGITS'(1))) == '0);
      changed = {sSel, sSeg} != {prevSel, prevSeg};
      if (changed)            cntD = CntW'(1);
      else if (cnt == CntMax) cntD = cnt;
      else                    cntD = cnt + CntW'(1);

      {hit, nib} = decodeHex(sSeg[6:0]);
      blank      = (sSeg[6:0] == 7'b0);

      capIdx = 3'd0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (sSel[i]) capIdx = 3'(i);
      end

      capture = 1'b0;
      stateD  = state;
      case (state)
         StIdle: begin
            if (oneHot) stateD = StTrack;
         end
         StTrack: begin
            if (!oneHot) begin
               stateD = StIdle;
            end else if (!changed && cntD == CntMax) begin
               capture = 1'b1;
               stateD  = StHeld;
            end
         end
         StHeld: begin
            if (!oneHot)      stateD = StIdle;
            else if (changed) stateD = StTrack;
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         segMeta <= '0;
         sSeg    <= '0;
         prevSeg <= '0;
         selMeta <= '0;
         sSel    <= '0;
         prevSel <= '0;
         cnt     <= '0;
         state   <= StIdle;
         valQ    <= '0;
         dpQ     <= '0;
         validQ  <= '0;
         errQ    <= '0;
         newQ    <= 1'b0;
         idxQ    <= '0;
         for (int i = 0; i < int'(DIGITS); i++) tmo[i] <= '0;
      end else begin
         segMeta <= bus.segIn;
         sSeg    <= segMeta;
         selMeta <= bus.digitSelIn;
         sSel    <= selMeta;
         prevSeg <= sSeg;
         prevSel <= sSel;
         cnt     <= cntD;
         state   <= stateD;
         newQ    <= capture;
         if (capture) idxQ <= capIdx;
         for (int i = 0; i < int'(DIGITS); i++) begin
            if (capture && sSel[i]) begin
               dpQ[i] <= sSeg[7];
               tmo[i] <= '0;
               if (hit) begin
                  valQ[4*i +: 4] <= nib;
                  validQ[i]      <= 1'b1;
                  errQ[i]        <= 1'b0;
               end else begin
                  // Blank and unrecognised patterns keep the old nibble.
                  validQ[i] <= 1'b0;
                  errQ[i]   <= !blank;
               end
            end else begin
               if (tmo[i] != TmoMax) tmo[i] <= tmo[i] + TmoW'(1);
               // Stale on the edge the counter reaches its limit.
               if (tmo[i] == TmoMax - TmoW'(1)) validQ[i] <= 1'b0;
            end
         end
      end
   end

   assign bus.valOut      = valQ;
   assign bus.dpOut       = dpQ;
   assign bus.validOut    = validQ;
   assign bus.errOut      = errQ;
   assign bus.newOut      = newQ;
   assign bus.digitIdxOut = idxQ;
endmodule
